// File: rtl/bit_count_unit.sv
// Multi-mode bit counter: ones, zeros, leading zeros or trailing zeros of a DATA_W operand,
// scanned BITS_PER_CYC bits per clock. Define BITCNT_EARLY_EXIT_EN to end a scan once the result is known.
module bit_count_unit #(
  parameter int DATA_W       = 16,
  parameter int BITS_PER_CYC = 2,
  parameter int CNT_W        = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] data_in,
  output logic              rdy,
  output logic              done,
  output logic [CNT_W-1:0]  cnt
);

  // Handshake: an op is accepted on a rising edge where start=1 and rdy=1; rdy drops
  // for the duration of the scan, and done pulses for one cycle with cnt valid in that cycle.

  localparam int N_CHUNK = DATA_W / BITS_PER_CYC;
  localparam int CHUNK_W = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
  localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(N_CHUNK - 1);
  // Bits entering from the top on each shift; zero-count mode fills with ones so they
  // never look like remaining zeros to the early-exit check.
  localparam logic [DATA_W-1:0] FILL_MASK = ~({DATA_W{1'b1}} >> BITS_PER_CYC);

  localparam logic [1:0] MODE_ONES  = 2'b00;
  localparam logic [1:0] MODE_ZEROS = 2'b01;
  localparam logic [1:0] MODE_LZ    = 2'b10;

  typedef enum logic {
    S_IDLE,
    S_COUNT
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0]       shift_q;
  logic [DATA_W-1:0]       shift_next;
  logic [1:0]              mode_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CHUNK_W-1:0]      chunk_q;
  logic                    found_q;
  logic                    done_q;

  logic [BITS_PER_CYC-1:0] chunk_bits;
  logic [CNT_W-1:0]        chunk_add;
  logic                    seen;
  logic                    early;
  logic                    last;
  logic                    accept;
  logic                    finish;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = v[DATA_W-1-i];
    end
    return r;
  endfunction

  assign chunk_bits = shift_q[BITS_PER_CYC-1:0];

  // Per-chunk contribution; zero-run modes stop adding once the first 1 has been seen.
  always_comb begin
    chunk_add = '0;
    seen      = found_q;
    for (int i = 0; i < BITS_PER_CYC; i++) begin
      case (mode_q)
        MODE_ONES: begin
          if (chunk_bits[i]) chunk_add = chunk_add + CNT_W'(1);
        end
        MODE_ZEROS: begin
          if (!chunk_bits[i]) chunk_add = chunk_add + CNT_W'(1);
        end
        default: begin
          if (chunk_bits[i]) seen = 1'b1;
          else if (!seen) chunk_add = chunk_add + CNT_W'(1);
        end
      endcase
    end
  end

  always_comb begin
    shift_next = shift_q >> BITS_PER_CYC;
    if (mode_q == MODE_ZEROS) shift_next = shift_next | FILL_MASK;
  end

`ifdef BITCNT_EARLY_EXIT_EN
  always_comb begin
    early = 1'b0;
    case (mode_q)
      MODE_ONES:  early = (shift_next == '0);
      MODE_ZEROS: early = &shift_next;
      default:    early = seen;
    endcase
  end
`else
  assign early = 1'b0;
`endif

  assign last = (chunk_q == LAST_CHUNK) || early;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        if (last) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Leading-zero mode loads the operand mirrored so the datapath always scans LSB-first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      mode_q  <= MODE_ONES;
      cnt_q   <= '0;
      chunk_q <= '0;
      found_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= finish;
      if (accept) begin
        shift_q <= (mode == MODE_LZ) ? bit_rev(data_in) : data_in;
        mode_q  <= mode;
        cnt_q   <= '0;
        chunk_q <= '0;
        found_q <= 1'b0;
      end else if (state_q == S_COUNT) begin
        shift_q <= shift_next;
        cnt_q   <= cnt_q + chunk_add;
        chunk_q <= chunk_q + CHUNK_W'(1);
        found_q <= seen;
      end
    end
  end

  assign rdy  = (state_q == S_IDLE);
  assign done = done_q;
  assign cnt  = cnt_q;

endmodule

// File: tb/tb_bit_count_unit.sv
// Scoreboard bench for bit_count_unit: directed corner ops, reset abort, ignored starts,
// and randomized back-to-back ops with start held high, checked against a reference model.
module tb_bit_count_unit;

  localparam int DW  = 16;
  localparam int BPC = 2;
  localparam int CW  = $clog2(DW + 1);
  localparam int NCH = DW / BPC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [DW-1:0] data_in = '0;
  logic          rdy;
  logic          done;
  logic [CW-1:0] cnt;

  logic [CW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  int            cyc = 0;
  int            n_total = 0;
  int            n_pass = 0;

  bit_count_unit #(
    .DATA_W(DW),
    .BITS_PER_CYC(BPC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .mode(mode),
    .data_in(data_in),
    .rdy(rdy),
    .done(done),
    .cnt(cnt)
  );

  // clock / cycle counter / watchdog
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // reference model: counts taken straight from the operand
  function automatic int model_cnt(input logic [1:0] m, input logic [DW-1:0] d);
    int c;
    c = 0;
    case (m)
      2'b00: c = $countones(d);
      2'b01: c = DW - $countones(d);
      2'b10: begin
        for (int i = DW - 1; i >= 0; i--) begin
          if (d[i]) break;
          c++;
        end
      end
      default: begin
        for (int i = 0; i < DW; i++) begin
          if (d[i]) break;
          c++;
        end
      end
    endcase
    return c;
  endfunction

  // cycles from accept edge to the edge that raises done
  function automatic int model_lat(input logic [1:0] m, input logic [DW-1:0] d);
`ifdef BITCNT_EARLY_EXIT_EN
    int            z;
    logic [DW-1:0] rem;
    logic [DW-1:0] live;
    z = model_cnt(m, d);
    for (int k = 1; k < NCH; k++) begin
      rem  = d >> (k * BPC);
      live = {DW{1'b1}} >> (k * BPC);
      case (m)
        2'b00:   if (rem == '0) return k;
        2'b01:   if (rem == live) return k;
        default: if (z < k * BPC) return k;
      endcase
    end
`endif
    return NCH;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    int            b;
    b = $urandom_range(0, DW - 1);
    case ($urandom_range(0, 5))
      0:       r = '0;
      1:       r = '1;
      2:       r = DW'(1) << b;
      3:       r = DW'({$urandom(), $urandom()});
      4:       r = DW'($urandom()) & DW'($urandom()) & DW'($urandom());
      default: r = ~(DW'(1) << b);
    endcase
    return r;
  endfunction

  // called at a negedge where rdy=1 and start=1: the op is accepted on the next posedge
  task automatic push_exp(input logic [1:0] m, input logic [DW-1:0] d);
    exp_q.push_back(CW'(model_cnt(m, d)));
    exp_cyc_q.push_back(cyc + 1 + model_lat(m, d));
  endtask

  // driver: one op with a single-cycle start pulse
  task automatic issue(input logic [1:0] m, input logic [DW-1:0] d);
    int w;
    w = 0;
    @(negedge clk);
    while (!rdy && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("rdy_before_issue", int'(rdy), 1);
    if (rdy) begin
      mode    = m;
      data_in = d;
      start   = 1'b1;
      push_exp(m, d);
      @(negedge clk);
      start = 1'b0;
      check("rdy_low_when_busy", int'(rdy), 0);
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("drain_outstanding", exp_q.size(), 0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: done=1 cnt=%0d with no outstanding op", cnt);
      end else begin
        logic [CW-1:0] e;
        int            ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("cnt", int'(cnt), int'(e));
        check("latency", cyc, ec);
        check("rdy_with_done", int'(rdy), 1);
      end
    end
  end

  initial begin
    #3;
    check("reset_rdy", int'(rdy), 1);
    check("reset_done", int'(done), 0);
    check("reset_cnt", int'(cnt), 0);
    @(negedge clk);
    rst = 1'b0;

    // corner results and minimum-latency case
    issue(2'b01, 16'h0000); drain();
    issue(2'b10, 16'h0100); drain();
    issue(2'b11, 16'h0000); drain();
    issue(2'b11, 16'h8000); drain();
    issue(2'b10, 16'h0000); drain();
    issue(2'b10, 16'h8001); drain();
    issue(2'b00, 16'h0003); drain();
    issue(2'b00, 16'hFFFF); drain();
    issue(2'b01, 16'hFFFF); drain();

    // start while busy is ignored; only one done expected
    issue(2'b00, 16'h0F0F);
    @(negedge clk);
    mode    = 2'b01;
    data_in = 16'hFFFF;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    drain();
    check("cnt_holds_after_done", int'(cnt), 8);

    // reset mid-op aborts without done
    issue(2'b00, 16'hFFFF);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    #1;
    check("abort_rdy", int'(rdy), 1);
    check("abort_cnt", int'(cnt), 0);
    check("abort_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue(2'b00, 16'h00F0); drain();

    // start held high: sweep low byte in mode 00, then random modes/data
    for (int n = 0; n < 256 + 1500; ) begin
      @(negedge clk);
      start = 1'b1;
      if (rdy) begin
        mode    = (n < 256) ? 2'b00 : 2'($urandom_range(0, 3));
        data_in = (n < 256) ? DW'(n) : rand_data();
        push_exp(mode, data_in);
        n++;
      end else begin
        mode    = 2'($urandom_range(0, 3));
        data_in = rand_data();
      end
    end
    @(negedge clk);
    start = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
